instr_mem_resp: RTL and testbench
=================================

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory size in 32-bit words, power of two, 16..4096.
REQ-002 Parameter WAIT_CYCLES, default 1: extra wait cycles before each response, 0..15.
REQ-003 Port CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Port RES  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 Port INSTR_REQ  in  1  fetch request from the controller, sampled each rising edge.
REQ-006 Port ADDR  in  32  byte address of the requested instruction, sampled with INSTR_REQ.
REQ-007 Port MEM_WE  in  1  memory load strobe.
REQ-008 Port MEM_WADDR  in  32  byte address for load.
REQ-009 Port MEM_WDATA  in  32  load data.
REQ-010 Port INSTR  out  32  returned instruction word, registered.
REQ-011 Port INSTR_VALID  out  1  one-cycle pulse marking INSTR valid.
REQ-012 Port BUSY  out  1  high while a fetch is outstanding.
REQ-013 Port ADDR_ERR  out  1  response flag: misaligned or out-of-range address.

Function
REQ-014 The block SHALL implement FSM states BOOT, IDLE, WAIT, RESP.
REQ-015 BOOT SHALL be entered on reset, capture address 0, and go to WAIT on the first edge after RES deasserts, so the controller receives an initial INSTR_VALID without requesting.
REQ-016 IDLE SHALL go to WAIT on an edge with INSTR_REQ=1 and capture ADDR on that edge; otherwise it stays in IDLE.
REQ-017 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit counter, then go to RESP.
REQ-018 With WAIT_CYCLES=0, WAIT SHALL last exactly one cycle.
REQ-019 The memory read SHALL occur on the edge entering RESP.
REQ-020 INSTR and ADDR_ERR SHALL be registered on the edge entering RESP.
REQ-021 INSTR_VALID SHALL be 1 only in RESP, for exactly one cycle.
REQ-022 RESP SHALL always return to IDLE.
REQ-023 Latency SHALL be exactly WAIT_CYCLES+2 edges from the request-sampling edge to the edge that ends the INSTR_VALID cycle.
REQ-024 BUSY SHALL be 1 in BOOT, WAIT and RESP, and 0 in IDLE.
REQ-025 INSTR_REQ outside IDLE SHALL be ignored, with no queuing and no error.
REQ-026 INSTR SHALL hold its last value until the next RESP.
REQ-027 Word index SHALL be ADDR[log2(DEPTH)+1:2].
REQ-028 If ADDR[1:0]!=0 or ADDR>=4*DEPTH, the response SHALL be INSTR=32'h00000013 (NOP) with ADDR_ERR=1.
REQ-029 ADDR_ERR SHALL be 0 whenever INSTR_VALID=0.
REQ-030 MEM_WE=1 SHALL write MEM_WDATA to the word at MEM_WADDR on the rising edge, in any state.
REQ-031 A load to a misaligned or out-of-range MEM_WADDR SHALL be dropped.
REQ-032 For a load and a read of the same word on the same edge, the read SHALL return the old data (read-before-write).
REQ-033 A load before the read edge SHALL be visible to the pending fetch.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-035 While RES=0, the block SHALL force: state=BOOT, INSTR=0, INSTR_VALID=0, ADDR_ERR=0, BUSY=1, wait counter=0, captured address=0.
REQ-036 Reset asserted mid-fetch (WAIT or RESP) SHALL abort the fetch immediately, with no INSTR_VALID pulse; a boot fetch of address 0 follows release.

Verification
REQ-037 Load word0=0x00500093, WAIT_CYCLES=1, release RES -> INSTR_VALID pulses 3 edges after release with INSTR=0x00500093, ADDR_ERR=0.
REQ-038 INSTR_REQ pulse with ADDR=0x8, word2=0x002081B3 -> BUSY=1 next cycle; INSTR_VALID one cycle with INSTR=0x002081B3, exactly WAIT_CYCLES+2 edges after the request edge.
REQ-039 ADDR=0x6, then ADDR=4*DEPTH -> each response INSTR=0x00000013, ADDR_ERR=1.
REQ-040 INSTR_REQ held high for 10 cycles, WAIT_CYCLES=0 -> one response every 3 cycles (IDLE/WAIT/RESP), no extra pulses.
REQ-041 RES=0 during WAIT -> no INSTR_VALID, outputs at reset values; after release a boot fetch of address 0.
REQ-042 MEM_WE to the pending word during WAIT -> new data returned; the same write coincident with the RESP-entry edge -> old data returned.

Source files
------------

// File: rtl/instr_mem_resp_if.sv
// rtl/instr_mem_resp_if.sv - fetch request/response and memory-load bus for instr_mem_resp
//
// Signals:
//   INSTR_REQ    controller -> memory  fetch request, sampled on rising edge
//   ADDR         controller -> memory  byte address of the instruction to fetch
//   MEM_WE       loader     -> memory  load strobe
//   MEM_WADDR    loader     -> memory  byte address for the load
//   MEM_WDATA    loader     -> memory  load data
//   INSTR        memory -> controller  registered instruction word
//   INSTR_VALID  memory -> controller  one-cycle response pulse
//   BUSY         memory -> controller  fetch outstanding
//   ADDR_ERR     memory -> controller  response flag for misaligned/out-of-range address
interface instr_mem_resp_if;
    logic        INSTR_REQ;
    logic [31:0] ADDR;
    logic        MEM_WE;
    logic [31:0] MEM_WADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        BUSY;
    logic        ADDR_ERR;

    modport master (
        output INSTR_REQ, ADDR, MEM_WE, MEM_WADDR, MEM_WDATA,
        input  INSTR, INSTR_VALID, BUSY, ADDR_ERR
    );

    modport slave (
        input  INSTR_REQ, ADDR, MEM_WE, MEM_WADDR, MEM_WDATA,
        output INSTR, INSTR_VALID, BUSY, ADDR_ERR
    );
endinterface

// File: rtl/instr_mem_resp.sv
// rtl/instr_mem_resp.sv - instruction memory with fixed-latency fetch response
//
// Ports:
//   CLK   single clock, rising edge
//   RES   asynchronous active-low reset
//   bus   instr_mem_resp_if.slave: fetch request/response and load port
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two, 16..4096)
//   WAIT_CYCLES  extra wait cycles before each response (0..15)
module instr_mem_resp #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RES,
    instr_mem_resp_if.slave   bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        addr_err_q, addr_err_d;

    // Contents survive reset so a program loaded while RES is low is fetched at boot.
    logic [31:0] mem_q [DEPTH];

    logic          rd_bad;
    logic          wr_bad;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    // Any set bit above the word index means the byte address is >= 4*DEPTH.
    assign rd_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign wr_bad = (bus.MEM_WADDR[1:0] != 2'b00) || (bus.MEM_WADDR[31:AW+2] != '0);
    assign rd_idx = addr_q[AW+1:2];
    assign wr_idx = bus.MEM_WADDR[AW+1:2];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        addr_err_d = 1'b0;   // error flag lives only for the RESP cycle
        unique case (state_q)
            BOOT: begin
                addr_d     = '0;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            IDLE: begin
                if (bus.INSTR_REQ) begin
                    addr_d     = bus.ADDR;
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // WAIT spans WAIT_CYCLES+1 cycles so a zero setting still takes one cycle.
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = RESP;
                    // Read happens on this edge; a load on the same edge lands afterwards.
                    instr_d    = rd_bad ? NOP_INSTR : mem_q[rd_idx];
                    addr_err_d = rd_bad;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q    <= BOOT;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            instr_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (bus.MEM_WE && !wr_bad) begin
            mem_q[wr_idx] <= bus.MEM_WDATA;
        end
    end

    assign bus.INSTR       = instr_q;
    assign bus.INSTR_VALID = (state_q == RESP);
    assign bus.BUSY        = (state_q != IDLE);
    assign bus.ADDR_ERR    = addr_err_q;

endmodule

// File: tb/tb_instr_mem_resp.sv
// tb/tb_instr_mem_resp.sv - self-checking bench for instr_mem_resp
module tb_instr_mem_resp;

    localparam int          DEPTH = 256;
    localparam int          W     = 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic CLK;
    logic RES;
    logic RES0;
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    instr_mem_resp_if bus ();
    instr_mem_resp_if bus0 ();

    instr_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus)
    );

    instr_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .CLK (CLK),
        .RES (RES0),
        .bus (bus0)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop: every response must match the oldest expectation, including its cycle.
    always @(negedge CLK) begin
        if (bus.INSTR_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_instr", bus.INSTR, mon_e.instr);
                check("resp_err", 32'(bus.ADDR_ERR), 32'(mon_e.err));
                check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end else begin
            check("err_without_valid", 32'(bus.ADDR_ERR), 32'd0);
        end
    end

    // Called at the negedge before the sampling edge; response appears W+2 edges later.
    task automatic push(input logic [31:0] instr, input logic err);
        exp_t e;
        e.instr = instr;
        e.err   = err;
        e.cyc   = cyc + W + 2;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.BUSY !== 1'b0 && k < 60) begin
            @(negedge CLK);
            k++;
        end
        check("idle_reached", 32'(bus.BUSY), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MEM_WE    = 1'b1;
        bus.MEM_WADDR = a;
        bus.MEM_WDATA = d;
        @(negedge CLK);
        bus.MEM_WE    = 1'b0;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d);
        bus0.MEM_WE    = 1'b1;
        bus0.MEM_WADDR = a;
        bus0.MEM_WDATA = d;
        @(negedge CLK);
        bus0.MEM_WE    = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] e, input logic err);
        wait_idle();
        bus.INSTR_REQ = 1'b1;
        bus.ADDR      = a;
        push(e, err);
        @(negedge CLK);
        bus.INSTR_REQ = 1'b0;
        check("busy_after_req", 32'(bus.BUSY), 32'd1);
    endtask

    initial begin
        int c;
        int pulses;
        int k;

        RES  = 1'b0;
        RES0 = 1'b0;
        bus.INSTR_REQ  = 1'b0; bus.ADDR  = '0; bus.MEM_WE  = 1'b0; bus.MEM_WADDR  = '0; bus.MEM_WDATA  = '0;
        bus0.INSTR_REQ = 1'b0; bus0.ADDR = '0; bus0.MEM_WE = 1'b0; bus0.MEM_WADDR = '0; bus0.MEM_WDATA = '0;

        repeat (2) @(negedge CLK);
        check("rst_instr", bus.INSTR, 32'd0);
        check("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd1);
        check("rst_err", 32'(bus.ADDR_ERR), 32'd0);

        // Program load while held in reset
        wr(32'h0, 32'h0050_0093);
        wr(32'h4, 32'h1111_1111);
        wr(32'h8, 32'h0020_81B3);
        wr(32'(4 * DEPTH - 4), 32'hCAFE_F00D);
        wr0(32'h4, 32'h0000_A0B3);
        check("rst_hold_busy", 32'(bus.BUSY), 32'd1);
        check("rst_hold_valid", 32'(bus.INSTR_VALID), 32'd0);

        // Boot fetch of word 0 without any request
        push(32'h0050_0093, 1'b0);
        RES  = 1'b1;
        RES0 = 1'b1;

        req(32'h8, 32'h0020_81B3, 1'b0);
        req(32'h6, NOP, 1'b1);
        req(32'(4 * DEPTH), NOP, 1'b1);
        req(32'hFFFF_FFF8, NOP, 1'b1);
        req(32'(4 * DEPTH - 4), 32'hCAFE_F00D, 1'b0);

        wait_idle();
        repeat (3) @(negedge CLK);
        check("instr_hold", bus.INSTR, 32'hCAFE_F00D);

        // Request held high: only samples taken in IDLE produce responses (period W+3)
        wait_idle();
        bus.INSTR_REQ = 1'b1;
        bus.ADDR      = 32'h8;
        push(32'h0020_81B3, 1'b0);
        repeat (W + 3) @(negedge CLK);
        push(32'h0020_81B3, 1'b0);
        repeat (W + 3) @(negedge CLK);
        bus.INSTR_REQ = 1'b0;

        // Reset asserted during WAIT aborts the fetch
        wait_idle();
        bus.INSTR_REQ = 1'b1;
        bus.ADDR      = 32'h8;
        @(negedge CLK);
        bus.INSTR_REQ = 1'b0;
        RES = 1'b0;
        #1;
        check("abort_instr", bus.INSTR, 32'd0);
        check("abort_valid", 32'(bus.INSTR_VALID), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd1);
        check("abort_err", 32'(bus.ADDR_ERR), 32'd0);
        repeat (2) @(negedge CLK);
        check("abort_no_valid", 32'(bus.INSTR_VALID), 32'd0);
        push(32'h0050_0093, 1'b0);
        RES = 1'b1;

        // Load during WAIT is visible to the pending fetch
        wait_idle();
        bus.INSTR_REQ = 1'b1;
        bus.ADDR      = 32'h4;
        push(32'h2222_2222, 1'b0);
        @(negedge CLK);
        bus.INSTR_REQ = 1'b0;
        wr(32'h4, 32'h2222_2222);

        // Load on the RESP-entry edge: fetch returns the old word
        wait_idle();
        bus.INSTR_REQ = 1'b1;
        bus.ADDR      = 32'h4;
        push(32'h2222_2222, 1'b0);
        @(negedge CLK);
        bus.INSTR_REQ = 1'b0;
        @(negedge CLK);
        wr(32'h4, 32'h3333_3333);

        // Misaligned and out-of-range loads are dropped
        wait_idle();
        wr(32'h5, 32'hDEAD_BEEF);
        wr(32'(4 * DEPTH + 4), 32'hDEAD_BEEF);
        req(32'h4, 32'h3333_3333, 1'b0);

        // Zero-wait instance: REQ held 10 cycles gives a pulse every 3 cycles
        check("w0_idle", 32'(bus0.BUSY), 32'd0);
        c      = cyc;
        pulses = 0;
        bus0.INSTR_REQ = 1'b1;
        bus0.ADDR      = 32'h4;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            if (i == 10) bus0.INSTR_REQ = 1'b0;
            if (bus0.INSTR_VALID === 1'b1) begin
                pulses++;
                check("w0_phase", 32'((cyc - c) % 3), 32'd2);
                check("w0_instr", bus0.INSTR, 32'h0000_A0B3);
            end
        end
        check("w0_pulse_count", 32'(pulses), 32'd4);

        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge CLK);
            k++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
